// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit (states, PC step, fetch entry).
// The optional fetch buffer is enabled with IF_FETCH_BUF_EN.
package inst_fetch_pkg;

   typedef logic [31:0] inst_addr_t;
   typedef logic [31:0] inst_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_HOLD = 2'b10
   } fetch_state_e;

   localparam inst_addr_t PC_STEP      = 32'd4;
   localparam inst_t      ZERO_WORD    = 32'h0000_0000;
   localparam logic       CHIP_ENABLE  = 1'b1;
   localparam logic       CHIP_DISABLE = 1'b0;
   localparam logic       RST_ENABLE   = 1'b1;

   typedef struct packed {
      inst_addr_t pc;
      inst_t      inst;
   } fetch_entry_t;

   typedef struct packed {
      fetch_entry_t entry;
      logic         valid;
   } fetch_out_t;

   function automatic inst_addr_t word_align(input inst_addr_t addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

   function automatic bit is_pow2(input int unsigned value);
      return (value != 0) && ((value & (value - 1)) == 0);
   endfunction

   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-side bus: redirect input, ROM read port and the IF/ID valid/ready output.
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic       branch_flag_i;
   inst_addr_t branch_target_i;
   logic       id_ready_i;
   logic       rom_ce_o;
   inst_addr_t rom_addr_o;
   inst_t      rom_inst_i;
   inst_addr_t if_pc_o;
   inst_t      if_inst_o;
   logic       if_valid_o;

   modport master (
      input  branch_flag_i, branch_target_i, id_ready_i, rom_inst_i,
      output rom_ce_o, rom_addr_o, if_pc_o, if_inst_o, if_valid_o
   );

   modport slave (
      output branch_flag_i, branch_target_i, id_ready_i, rom_inst_i,
      input  rom_ce_o, rom_addr_o, if_pc_o, if_inst_o, if_valid_o
   );

endinterface

// File: rtl/inst_fetch_fetch_buf.sv
// Synchronous FIFO holding prefetched {pc, inst} entries; used only under IF_FETCH_BUF_EN.
module fetch_buf
   import inst_fetch_pkg::*;
#(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        data_i,
   input  logic                    pop_i,
   output logic [WIDTH-1:0]        data_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic [ptr_w(DEPTH):0]   count_o
);

   localparam int unsigned AW = ptr_w(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, rd_q;
   logic             do_push, do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign count_o = wr_q - rd_q;
   assign full_o  = (count_o == (AW + 1)'(DEPTH));
   assign empty_o = (count_o == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: owns the PC, reads the ROM and presents {pc, inst} to IF/ID.
// Define IF_FETCH_BUF_EN to insert a BUF_DEPTH-entry prefetch FIFO between ROM and output.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter inst_addr_t  RESET_PC  = 32'h0000_0000,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   inst_fetch_if.master fetch_bus
);

   fetch_state_e state_q, state_d;
   inst_addr_t   pc_q, pc_d;
   fetch_out_t   out_q, out_d;

   logic         redirect, slot_free, fetch_en, load_en;
   fetch_entry_t load_entry;

   assign redirect  = fetch_bus.branch_flag_i;
   assign slot_free = !out_q.valid || fetch_bus.id_ready_i;

   // BUF_DEPTH must be a power of two; a bad value elaborates this marker block.
   if (!is_pow2(BUF_DEPTH)) begin : g_bad_buf_depth
   end

`ifdef IF_FETCH_BUF_EN
   localparam int unsigned BUF_AW = ptr_w(BUF_DEPTH);

   logic [$bits(fetch_entry_t)-1:0] buf_wdata, buf_rdata;
   logic                            buf_full, buf_empty;
   logic [BUF_AW:0]                 buf_count;

   // Prefetch runs in RUN and HOLD; HOLD only freezes the output register.
   assign fetch_en   = (state_q != S_IDLE) && !buf_full && !redirect;
   assign load_en    = (state_q != S_IDLE) && slot_free && !buf_empty && !redirect;
   assign buf_wdata  = {pc_q, fetch_bus.rom_inst_i};
   assign load_entry = fetch_entry_t'(buf_rdata);

   fetch_buf #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (BUF_DEPTH)
   ) u_fetch_buf (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect),
      .push_i  (fetch_en),
      .data_i  (buf_wdata),
      .pop_i   (load_en),
      .data_o  (buf_rdata),
      .full_o  (buf_full),
      .empty_o (buf_empty),
      .count_o (buf_count)
   );
`else
   // Without the buffer, back-pressure stalls the PC directly.
   assign fetch_en   = (state_q == S_RUN) && slot_free && !redirect;
   assign load_en    = fetch_en;
   assign load_entry = '{pc: pc_q, inst: fetch_bus.rom_inst_i};
`endif

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  state_d = S_RUN;
         S_RUN:   if (out_q.valid && !fetch_bus.id_ready_i) state_d = S_HOLD;
         S_HOLD:  if (fetch_bus.id_ready_i) state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
      if (redirect) state_d = S_RUN;
   end

   always_comb begin
      pc_d = pc_q;
      if (redirect)      pc_d = word_align(fetch_bus.branch_target_i);
      else if (fetch_en) pc_d = pc_q + PC_STEP;
   end

   always_comb begin
      out_d = out_q;
      if (redirect)                                       out_d.valid = 1'b0;
      else if (load_en)                                   out_d = '{entry: load_entry, valid: 1'b1};
      else if (out_q.valid && fetch_bus.id_ready_i)       out_d.valid = 1'b0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state_q <= S_IDLE;
         pc_q    <= word_align(RESET_PC);
         out_q   <= '{entry: '{pc: '0, inst: ZERO_WORD}, valid: 1'b0};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
      end
   end

   assign fetch_bus.rom_ce_o   = fetch_en ? CHIP_ENABLE : CHIP_DISABLE;
   assign fetch_bus.rom_addr_o = word_align(pc_q);
   assign fetch_bus.if_pc_o    = out_q.entry.pc;
   assign fetch_bus.if_inst_o  = out_q.entry.inst;
   assign fetch_bus.if_valid_o = out_q.valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed literal checks plus randomized traffic against a
// behavioural model and an in-order stream scoreboard. Honours IF_FETCH_BUF_EN when defined.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          BUF_DEPTH = 2;
   localparam int          M_IDLE = 0, M_RUN = 1, M_HOLD = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   inst_fetch_if bus ();

   inst_fetch #(
      .RESET_PC  (RESET_PC),
      .BUF_DEPTH (BUF_DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .fetch_bus (bus)
   );

   always #5 clk = ~clk;

   // ROM word i holds the value i.
   assign bus.rom_inst_i = bus.rom_addr_o >> 2;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (state after the next rising edge) ----------------
   int          m_phase = M_IDLE;
   logic [31:0] m_pc = '0, m_out_pc = '0, m_out_inst = '0;
   bit          m_valid = 1'b0;
   bit          m_live  = 1'b0;
   logic [63:0] m_fifo[$];
   logic [31:0] s_next = RESET_PC;

   function automatic bit m_ce();
`ifdef IF_FETCH_BUF_EN
      return (m_phase != M_IDLE) && (m_fifo.size() < BUF_DEPTH) && !bus.branch_flag_i;
`else
      return (m_phase == M_RUN) && (!m_valid || bus.id_ready_i) && !bus.branch_flag_i;
`endif
   endfunction

   task automatic model_step();
      bit ce, rdy, xfer;
      ce   = m_ce();
      rdy  = bus.id_ready_i;
      xfer = m_valid && rdy;
      if (rst) begin
         m_phase = M_IDLE; m_pc = RESET_PC & 32'hFFFF_FFFC;
         m_valid = 0; m_out_pc = '0; m_out_inst = '0;
         m_fifo.delete();
         m_live = 1'b1;
      end else if (bus.branch_flag_i) begin
         m_phase = M_RUN;
         m_pc    = bus.branch_target_i & 32'hFFFF_FFFC;
         m_valid = 0;
         m_fifo.delete();
      end else begin
         if (m_phase == M_IDLE)                     m_phase = M_RUN;
         else if (m_phase == M_RUN && xfer == 0 && m_valid) m_phase = M_HOLD;
         else if (m_phase == M_HOLD && rdy)         m_phase = M_RUN;
`ifdef IF_FETCH_BUF_EN
         if ((!m_valid || rdy) && m_fifo.size() > 0) begin
            {m_out_pc, m_out_inst} = m_fifo.pop_front();
            m_valid = 1;
         end else if (xfer) m_valid = 0;
         if (ce) begin
            m_fifo.push_back({m_pc, m_pc >> 2});
            m_pc = m_pc + 32'd4;
         end
`else
         if (ce) begin
            m_out_pc = m_pc; m_out_inst = m_pc >> 2; m_valid = 1;
            m_pc = m_pc + 32'd4;
         end else if (xfer) m_valid = 0;
`endif
      end
   endtask

   // Compare process: check outputs against the model, then advance the model with the inputs
   // that the coming rising edge will sample.
   initial begin
      forever begin
         @(negedge clk);
         if (m_live) begin
            check("valid", bus.if_valid_o, m_valid);
            if (m_valid) begin
               check("if_pc", bus.if_pc_o, m_out_pc);
               check("if_inst", bus.if_inst_o, m_out_inst);
            end
            check("rom_ce", bus.rom_ce_o, m_ce());
            check("rom_addr", bus.rom_addr_o, m_pc);
            if (bus.if_valid_o && bus.id_ready_i && !bus.branch_flag_i && !rst) begin
               check("stream_pc", bus.if_pc_o, s_next);
               check("stream_inst", bus.if_inst_o, bus.if_pc_o >> 2);
               s_next = bus.if_pc_o + 32'd4;
            end
         end
         if (rst)                    s_next = RESET_PC;
         else if (bus.branch_flag_i) s_next = bus.branch_target_i & 32'hFFFF_FFFC;
         model_step();
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus.if_valid_o && n < 6) begin
         tick();
         #1;
         n++;
      end
      check(name, bus.if_valid_o, 1'b1);
   endtask

   initial begin
      bus.branch_flag_i   = 1'b0;
      bus.branch_target_i = '0;
      bus.id_ready_i      = 1'b1;
      rst                 = 1'b1;
      repeat (3) tick();
      #1;
      check("rst_valid", bus.if_valid_o, 1'b0);
      check("rst_ce", bus.rom_ce_o, 1'b0);
      check("rst_pc", bus.if_pc_o, 32'h0);
      check("rst_inst", bus.if_inst_o, 32'h0);
      rst = 1'b0;

`ifndef IF_FETCH_BUF_EN
      // Reset then run: one idle cycle, then consecutive words with 1-cycle latency.
      tick(); #1;
      check("t1_ce", bus.rom_ce_o, 1'b1);
      check("t1_addr", bus.rom_addr_o, 32'h0);
      tick(); #1;
      check("t1_pc0", bus.if_pc_o, 32'h0);
      check("t1_inst0", bus.if_inst_o, 32'h0);
      check("t1_valid", bus.if_valid_o, 1'b1);
      tick(); #1;
      check("t1_pc4", bus.if_pc_o, 32'h4);
      check("t1_inst1", bus.if_inst_o, 32'h1);
      tick(); #1;
      check("t1_pc8", bus.if_pc_o, 32'h8);
      check("t1_inst2", bus.if_inst_o, 32'h2);

      // Back-pressure for three cycles at pc 8.
      bus.id_ready_i = 1'b0; #1;
      check("t2_ce_block", bus.rom_ce_o, 1'b0);
      repeat (3) begin
         tick(); #1;
         check("t2_hold_pc", bus.if_pc_o, 32'h8);
         check("t2_hold_ce", bus.rom_ce_o, 1'b0);
      end
      bus.id_ready_i = 1'b1;
      tick(); #1;
      wait_valid("t2_resume");
      check("t2_next_pc", bus.if_pc_o, 32'hC);
      check("t2_next_inst", bus.if_inst_o, 32'h3);

      // Redirect while stalled.
      bus.id_ready_i = 1'b0;
      bus.branch_flag_i = 1'b1; bus.branch_target_i = 32'h43;
      tick();
      bus.branch_flag_i = 1'b0; bus.id_ready_i = 1'b1; #1;
      check("t3_valid_drop", bus.if_valid_o, 1'b0);
      check("t3_addr", bus.rom_addr_o, 32'h40);
      tick(); #1;
      check("t3_pc", bus.if_pc_o, 32'h40);
      check("t3_inst", bus.if_inst_o, 32'h10);

      // Redirect to the top word; pc wraps to zero.
      bus.branch_flag_i = 1'b1; bus.branch_target_i = 32'hFFFF_FFFC;
      tick();
      bus.branch_flag_i = 1'b0; #1;
      tick(); #1;
      check("t4_pc_top", bus.if_pc_o, 32'hFFFF_FFFC);
      check("t4_inst_top", bus.if_inst_o, 32'h3FFF_FFFF);
      tick(); #1;
      check("t4_pc_wrap", bus.if_pc_o, 32'h0);
      check("t4_valid", bus.if_valid_o, 1'b1);

      // Reset mid-stream.
      rst = 1'b1;
      tick();
      rst = 1'b0; #1;
      check("t5_valid", bus.if_valid_o, 1'b0);
      check("t5_ce", bus.rom_ce_o, 1'b0);
      wait_valid("t5_restart");
      check("t5_pc", bus.if_pc_o, RESET_PC);
`else
      // Prefetch buffer fills under back-pressure, then fetch stops.
      repeat (4) tick();
      bus.id_ready_i = 1'b0;
      repeat (5) tick();
      #1;
      check("t6_ce_full", bus.rom_ce_o, 1'b0);
      check("t6_valid", bus.if_valid_o, 1'b1);
      bus.id_ready_i = 1'b1;
      repeat (6) tick();
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         rst                 = ($urandom_range(0, 99) == 0);
         bus.id_ready_i      = ($urandom_range(0, 9) < 7);
         bus.branch_flag_i   = ($urandom_range(0, 19) == 0);
         bus.branch_target_i = ($urandom_range(0, 3) == 0) ?
                               (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
         tick();
      end
      rst = 1'b0; bus.branch_flag_i = 1'b0; bus.id_ready_i = 1'b1;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
